// File: rtl/opll_slot_scheduler.sv
// opll_slot_scheduler: drives the shared slot/stage timeline (18 slots x 4 stages)
// and funnels buffered CPU register writes into the register file during stage 3,
// the only stage in which no datapath reads the register file.
// The rhythm-mode flag only changes on frame boundaries, so it is stable across a frame.
module opll_slot_scheduler (
   input  logic       clk,
   input  logic       reset,
   input  logic       clkena,
   output logic [4:0] slot,
   output logic [1:0] stage,
   output logic       frame,
   input  logic       wr_valid,
   input  logic [5:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   output logic       reg_we,
   output logic [5:0] reg_addr,
   output logic [7:0] reg_data,
   output logic       wr_drop,
   output logic       rhythm
);

   localparam logic [4:0] LAST_SLOT   = 5'd17;
   localparam logic [1:0] LAST_STAGE  = 2'd3;
   localparam logic [5:0] RHYTHM_ADDR = 6'h0E;

   logic [4:0] slot_q, slot_d;
   logic [1:0] stage_q, stage_d;
   logic       buf_full_q, buf_full_d;
   logic [5:0] buf_addr_q, buf_addr_d;
   logic [7:0] buf_data_q, buf_data_d;
   logic       reg_we_q, reg_we_d;
   logic [5:0] reg_addr_q, reg_addr_d;
   logic [7:0] reg_data_q, reg_data_d;
   logic       wr_drop_q, wr_drop_d;
   logic       rhythm_q, rhythm_d;
   logic       rhythm_pending_q, rhythm_pending_d;

   logic       accept;
   logic       commit;
   logic       commit_ok;

   // Register addresses that actually exist in the OPLL register map.
   function automatic logic addr_valid(input logic [5:0] a);
      logic v;
      v = 1'b0;
      if (a <= 6'h07)
         v = 1'b1;
      else if (a == 6'h0E || a == 6'h0F)
         v = 1'b1;
      else if (a >= 6'h10 && a <= 6'h18)
         v = 1'b1;
      else if (a >= 6'h20 && a <= 6'h28)
         v = 1'b1;
      else if (a >= 6'h30 && a <= 6'h38)
         v = 1'b1;
      return v;
   endfunction

   // Next-state logic: timeline counters, write buffer, commit strobes and rhythm staging.
   always_comb begin
      slot_d           = slot_q;
      stage_d          = stage_q;
      buf_full_d       = buf_full_q;
      buf_addr_d       = buf_addr_q;
      buf_data_d       = buf_data_q;
      reg_we_d         = 1'b0;
      reg_addr_d       = reg_addr_q;
      reg_data_d       = reg_data_q;
      wr_drop_d        = 1'b0;
      rhythm_d         = rhythm_q;
      rhythm_pending_d = rhythm_pending_q;

      accept    = wr_valid && !buf_full_q;
      commit    = clkena && (stage_q == LAST_STAGE) && buf_full_q;
      commit_ok = commit && addr_valid(buf_addr_q);

      if (clkena) begin
         if (stage_q == LAST_STAGE) begin
            stage_d = 2'd0;
            slot_d  = (slot_q == LAST_SLOT) ? 5'd0 : slot_q + 5'd1;
         end else begin
            stage_d = stage_q + 2'd1;
         end
      end

      if (accept) begin
         buf_full_d = 1'b1;
         buf_addr_d = wr_addr;
         buf_data_d = wr_data;
      end else if (commit) begin
         buf_full_d = 1'b0;
      end

      if (commit_ok) begin
         reg_we_d   = 1'b1;
         reg_addr_d = buf_addr_q;
         reg_data_d = buf_data_q;
      end else if (commit) begin
         wr_drop_d = 1'b1;
      end

      if (commit_ok && buf_addr_q == RHYTHM_ADDR)
         rhythm_pending_d = buf_data_q[5];

      if (clkena && slot_q == LAST_SLOT && stage_q == LAST_STAGE)
         rhythm_d = rhythm_pending_q;
   end

   // State registers with asynchronous reset back to the start of a frame, buffer empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_q           <= 5'd0;
         stage_q          <= 2'd0;
         buf_full_q       <= 1'b0;
         buf_addr_q       <= 6'd0;
         buf_data_q       <= 8'd0;
         reg_we_q         <= 1'b0;
         reg_addr_q       <= 6'd0;
         reg_data_q       <= 8'd0;
         wr_drop_q        <= 1'b0;
         rhythm_q         <= 1'b0;
         rhythm_pending_q <= 1'b0;
      end else begin
         slot_q           <= slot_d;
         stage_q          <= stage_d;
         buf_full_q       <= buf_full_d;
         buf_addr_q       <= buf_addr_d;
         buf_data_q       <= buf_data_d;
         reg_we_q         <= reg_we_d;
         reg_addr_q       <= reg_addr_d;
         reg_data_q       <= reg_data_d;
         wr_drop_q        <= wr_drop_d;
         rhythm_q         <= rhythm_d;
         rhythm_pending_q <= rhythm_pending_d;
      end
   end

   assign slot     = slot_q;
   assign stage    = stage_q;
   assign frame    = (slot_q == 5'd0) && (stage_q == 2'd0);
   assign wr_ready = !buf_full_q;
   assign reg_we   = reg_we_q;
   assign reg_addr = reg_addr_q;
   assign reg_data = reg_data_q;
   assign wr_drop  = wr_drop_q;
   assign rhythm   = rhythm_q;

endmodule

// File: tb/tb_opll_slot_scheduler.sv
// Testbench for opll_slot_scheduler: directed steps with a commit scoreboard.
module tb_opll_slot_scheduler;

   logic       clk;
   logic       reset;
   logic       clkena;
   logic [4:0] slot;
   logic [1:0] stage;
   logic       frame;
   logic       wr_valid;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       reg_we;
   logic [5:0] reg_addr;
   logic [7:0] reg_data;
   logic       wr_drop;
   logic       rhythm;

   typedef struct {
      logic       we;
      logic       drop;
      logic [5:0] addr;
      logic [7:0] data;
      logic [4:0] slot;
   } commit_t;

   commit_t sb[$];

   int errors = 0;
   int checks = 0;
   int enCount = 0;
   int frameCount = 0;

   opll_slot_scheduler dut (
      .clk      (clk),
      .reset    (reset),
      .clkena   (clkena),
      .slot     (slot),
      .stage    (stage),
      .frame    (frame),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ready (wr_ready),
      .reg_we   (reg_we),
      .reg_addr (reg_addr),
      .reg_data (reg_data),
      .wr_drop  (wr_drop),
      .rhythm   (rhythm)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock edge with the given enable and an optional single-cycle write request.
   task automatic applyStimulus(input logic en, input logic valid, input logic [5:0] addr, input logic [7:0] data);
      clkena   = en;
      wr_valid = valid;
      wr_addr  = addr;
      wr_data  = data;
      @(posedge clk);
      if (en)
         enCount++;
      #1;
      wr_valid = 1'b0;
   endtask

   task automatic step();
      applyStimulus(1'b1, 1'b0, 6'd0, 8'd0);
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_slot"}, 32'(slot), 32'((enCount % 72) / 4));
      checkOutput({tag, "_stage"}, 32'(stage), 32'(enCount % 4));
   endtask

   task automatic advanceTo(input int pos);
      int guard;
      guard = 0;
      while ((enCount % 72) != pos && guard < 200) begin
         step();
         guard++;
      end
      checkOutput("advance_bound", 32'(enCount % 72), 32'(pos));
   endtask

   task automatic pushCommit(input logic we, input logic drop, input logic [5:0] a, input logic [7:0] d, input logic [4:0] s);
      commit_t c;
      c.we   = we;
      c.drop = drop;
      c.addr = a;
      c.data = d;
      c.slot = s;
      sb.push_back(c);
   endtask

   // Scoreboard monitor: every commit strobe must match the oldest expected commit.
   always @(negedge clk) begin
      if (!reset && (reg_we || wr_drop)) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_strobe", 32'({reg_we, wr_drop}), 32'd0);
         end else begin
            commit_t e;
            e = sb.pop_front();
            checkOutput("sb_we", 32'(reg_we), 32'(e.we));
            checkOutput("sb_drop", 32'(wr_drop), 32'(e.drop));
            checkOutput("sb_addr", 32'(reg_addr), 32'(e.addr));
            checkOutput("sb_data", 32'(reg_data), 32'(e.data));
            checkOutput("sb_slot", 32'(slot), 32'(e.slot));
            checkOutput("sb_stage", 32'(stage), 32'd0);
         end
      end
   end

   // Directed sequence.
   initial begin
      reset    = 1'b1;
      clkena   = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = 6'd0;
      wr_data  = 8'd0;
      #12;
      checkOutput("rst_slot", 32'(slot), 32'd0);
      checkOutput("rst_stage", 32'(stage), 32'd0);
      checkOutput("rst_frame", 32'(frame), 32'd1);
      checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("rst_reg_we", 32'(reg_we), 32'd0);
      checkOutput("rst_reg_addr", 32'(reg_addr), 32'd0);
      checkOutput("rst_reg_data", 32'(reg_data), 32'd0);
      checkOutput("rst_wr_drop", 32'(wr_drop), 32'd0);
      checkOutput("rst_rhythm", 32'(rhythm), 32'd0);
      #4;
      reset = 1'b0;

      $display("[TB] two full frames with clkena high");
      for (int i = 0; i < 144; i++) begin
         checkCounters("run");
         checkOutput("run_frame", 32'(frame), 32'((enCount % 72) == 0));
         if (frame)
            frameCount++;
         step();
      end
      checkOutput("frame_count", 32'(frameCount), 32'd2);
      checkCounters("run_wrap");

      $display("[TB] clkena toggling");
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i % 2) == 0, 1'b0, 6'd0, 8'd0);
         checkCounters("toggle");
      end
      checkOutput("toggle_end_slot", 32'(slot), 32'd1);
      checkOutput("toggle_end_stage", 32'(stage), 32'd1);

      $display("[TB] valid write 0x10 <- 0x5A at slot 2 stage 0");
      advanceTo(8);
      pushCommit(1'b1, 1'b0, 6'h10, 8'h5A, 5'd3);
      applyStimulus(1'b1, 1'b1, 6'h10, 8'h5A);
      checkOutput("w1_ready_low", 32'(wr_ready), 32'd0);
      step();
      step();
      checkOutput("w1_no_early_we", 32'(reg_we), 32'd0);
      step();
      checkOutput("w1_reg_we", 32'(reg_we), 32'd1);
      checkOutput("w1_ready_back", 32'(wr_ready), 32'd1);
      step();
      checkOutput("w1_we_pulse_end", 32'(reg_we), 32'd0);

      $display("[TB] write accepted on a stage-3 edge, then gapped enable");
      advanceTo(15);
      pushCommit(1'b1, 1'b0, 6'h20, 8'h11, 5'd5);
      applyStimulus(1'b1, 1'b1, 6'h20, 8'h11);
      checkOutput("w2_not_same_edge", 32'(reg_we), 32'd0);
      for (int i = 0; i < 6; i++)
         applyStimulus((i % 2) == 1, 1'b0, 6'd0, 8'd0);
      checkOutput("w2_still_pending", 32'(wr_ready), 32'd0);
      applyStimulus(1'b0, 1'b0, 6'd0, 8'd0);
      checkOutput("w2_hold_no_we", 32'(reg_we), 32'd0);
      applyStimulus(1'b1, 1'b0, 6'd0, 8'd0);
      checkOutput("w2_reg_we", 32'(reg_we), 32'd1);

      $display("[TB] invalid address 0x09");
      pushCommit(1'b0, 1'b1, 6'h20, 8'h11, 5'd6);
      applyStimulus(1'b1, 1'b1, 6'h09, 8'hA5);
      checkOutput("w3_ready_low", 32'(wr_ready), 32'd0);
      step();
      step();
      step();
      checkOutput("w3_drop", 32'(wr_drop), 32'd1);
      checkOutput("w3_no_we", 32'(reg_we), 32'd0);
      checkOutput("w3_addr_kept", 32'(reg_addr), 32'h20);
      step();
      checkOutput("w3_drop_end", 32'(wr_drop), 32'd0);

      $display("[TB] rhythm enable committed in slot 5");
      advanceTo(20);
      pushCommit(1'b1, 1'b0, 6'h0E, 8'h20, 5'd6);
      applyStimulus(1'b1, 1'b1, 6'h0E, 8'h20);
      while ((enCount % 72) != 0) begin
         checkOutput("rhythm_hold0", 32'(rhythm), 32'd0);
         step();
      end
      checkOutput("rhythm_on", 32'(rhythm), 32'd1);
      for (int i = 0; i < 8; i++) begin
         step();
         checkOutput("rhythm_stable1", 32'(rhythm), 32'd1);
      end

      $display("[TB] rhythm disable committed in slot 17 stage 3");
      advanceTo(68);
      pushCommit(1'b1, 1'b0, 6'h0E, 8'h00, 5'd0);
      applyStimulus(1'b1, 1'b1, 6'h0E, 8'h00);
      step();
      step();
      step();
      checkCounters("late_wrap");
      checkOutput("rhythm_late_old", 32'(rhythm), 32'd1);
      advanceTo(71);
      checkOutput("rhythm_late_frame", 32'(rhythm), 32'd1);
      step();
      checkOutput("rhythm_late_off", 32'(rhythm), 32'd0);

      $display("[TB] reset with a write pending");
      advanceTo(4);
      applyStimulus(1'b1, 1'b1, 6'h30, 8'h77);
      checkOutput("w4_ready_low", 32'(wr_ready), 32'd0);
      step();
      reset = 1'b1;
      #3;
      checkOutput("mid_rst_slot", 32'(slot), 32'd0);
      checkOutput("mid_rst_stage", 32'(stage), 32'd0);
      checkOutput("mid_rst_ready", 32'(wr_ready), 32'd1);
      checkOutput("mid_rst_we", 32'(reg_we), 32'd0);
      checkOutput("mid_rst_addr", 32'(reg_addr), 32'd0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      enCount = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         checkCounters("post_rst");
         checkOutput("post_rst_no_we", 32'(reg_we), 32'd0);
      end

      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/opll_slot_scheduler.md
# opll_slot_scheduler

Sequences the VM2413 slot/stage timeline and arbitrates CPU register writes into the register file feeding the phase generator and other per-slot datapaths. It drives the shared `slot`/`stage` counters: 18 slots × 4 stages, so one sample frame is 72 enabled cycles. It also holds one pending CPU write and commits it only in stage 3, when no datapath reads the register file. Rhythm-mode changes are deferred to the frame boundary.

## Interface
Parameters: none (slot count 18 and stage count 4 are fixed by the datapath).

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- clkena  in  1  datapath advance enable; counters move only when high
- slot  out  5  current slot, 0..17
- stage  out  2  current stage, 0..3
- frame  out  1  high while slot==0 && stage==0 (decoded from registered counters)
- wr_valid  in  1  CPU write request
- wr_addr  in  6  OPLL register address
- wr_data  in  8  write data
- wr_ready  out  1  ==!buf_full; a write is accepted on a clk edge with wr_valid && wr_ready
- reg_we  out  1  register-file write strobe, one clk wide
- reg_addr  out  6  committed address
- reg_data  out  8  committed data
- wr_drop  out  1  one-clk pulse: buffered write had an invalid address and was discarded
- rhythm  out  1  rhythm-mode flag (reg 0x0E bit 5) as seen by the datapath

## Operation
- Counter: on each clk edge with clkena=1, stage increments.
  - stage 3→0 increments slot.
  - slot 17 with stage 3 wraps to slot 0, stage 0.
  - clkena=0 holds slot and stage.
- Write buffer: one entry, {addr, data, full}.
  - Accept is independent of clkena: wr_valid && !full loads the entry and sets full.
  - wr_valid while full is ignored; the requester holds the request until ready.
- Commit happens on the clk edge where clkena=1 && stage==3 && full. full clears at that edge.
  - Valid address (0x00–0x07, 0x0E, 0x0F, 0x10–0x18, 0x20–0x28, 0x30–0x38): reg_we<=1, reg_addr/reg_data<=entry.
  - Invalid address: wr_drop<=1, reg_we stays 0, reg_addr/reg_data unchanged.
  - reg_we and wr_drop return to 0 on the next clk edge, independent of clkena.
- Only one commit occurs per stage-3 slot, i.e. at most one write per 4 enabled cycles.
- Rhythm:
  - A committed write to 0x0E loads rhythm_pending <= wr_data[5].
  - rhythm <= rhythm_pending on the clk edge with clkena=1, slot==17, stage==3.
  - rhythm is therefore constant across every frame.
- Reset values: slot=0, stage=0, frame=1, wr_ready=1, reg_we=0, reg_addr=0, reg_data=0, wr_drop=0, rhythm=0, rhythm_pending=0, buffer empty.
- Reset mid-operation discards any pending write without a strobe and returns the counters to slot 0, stage 0.

## Timing
- Counter latency: the (slot, stage) change is visible one clk after the enabling edge.
- Write path:
  - An accept at edge t sets wr_ready=0 after t.
  - The earliest commit is the first edge after t with clkena=1 && stage==3.
  - A write accepted on a stage-3 enabled edge is not committed on that edge; the next opportunity is 4 enabled cycles later.
  - reg_we is high for the clk cycle after the commit edge. wr_ready returns to 1 in that same cycle, so back-to-back writes can be accepted immediately.
- Worst-case acceptance-to-commit: 4 enabled cycles plus clkena gaps.
- Rhythm latency: a 0x0E commit in any slot takes effect at the next frame start, up to 72 enabled cycles later. A 0x0E commit in slot 17 stage 3 updates pending on the same edge that samples it, so that frame sees the old pending value and the new value applies one frame later.
- frame is high for exactly 1 of every 72 enabled cycles.

## Test plan
- Reset, then clkena held at 1 for 144 clk → slot/stage sequence 0/0,0/1…17/3,0/0 twice; frame high at cycles 0 and 72 only.
- clkena toggling 1,0,1,0 → counters advance only on enabled edges; a 5-enabled-cycle run ends at slot 1, stage 1.
- Write 0x10←0x5A accepted at slot 2 stage 0 → wr_ready low; single reg_we pulse with addr 0x10, data 0x5A after the slot 2 stage 3 edge; wr_ready high again.
- Write to 0x09 (invalid) → wr_drop one-clk pulse at the stage-3 commit, no reg_we, reg_addr unchanged.
- Write 0x0E←0x20 committed in slot 5 → rhythm stays 0 until the slot 17 stage 3 edge, then 1 from the slot 0 stage 0 cycle onward.
- Write accepted, then reset asserted before stage 3 → no reg_we, wr_ready=1, slot/stage=0/0; after release, normal counting resumes.
